// File: rtl/ledwalker_pkg.sv
// Shared encodings for the LED walker: run-time modes and walk direction.
package ledwalker_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_WRAPUP = 2'd1,
    MODE_WRAPDN = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

endpackage

// File: rtl/strobe_gen.sv
// Step-rate divider: counts 0..DIV-1 while enabled and strobes on the last count.
module strobe_gen #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_stb
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("strobe_gen: DIV must be >= 2");
    end
  endgenerate

  logic [CW-1:0] cnt_q, cnt_d;

  // Holding the count while disabled keeps the step phase across pauses.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)
      cnt_d = '0;
    else if (i_en)
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_stb = i_en && (cnt_q == CNT_LAST);

  a_cnt_range: assert property (@(posedge i_clk) disable iff (i_reset)
    int'(cnt_q) < DIV);

endmodule

// File: rtl/ledwalker_n.sv
// LED walker: moves one lit LED across NLEDS outputs at a divided step rate,
// with bounce / wrap-up / wrap-down / hold modes and a sweep-complete pulse.
module ledwalker_n
  import ledwalker_pkg::*;
#(
  parameter int NLEDS         = 8,
  parameter int CLOCK_RATE_HZ = 50_000_000,
  parameter int STEP_RATE_HZ  = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_en,
  input  logic                     i_restart,
  input  logic [1:0]               i_mode,
  output logic [NLEDS-1:0]         o_led,
  output logic [$clog2(NLEDS)-1:0] o_pos,
  output logic                     o_sweep
);

  localparam int PW  = $clog2(NLEDS);
  localparam int DIV = CLOCK_RATE_HZ / STEP_RATE_HZ;
  localparam logic [PW-1:0] POS_LAST = PW'(NLEDS - 1);

  generate
    if (NLEDS < 2 || NLEDS > 32) begin : g_bad_nleds
      $error("ledwalker_n: NLEDS must be in 2..32");
    end
  endgenerate

  logic             stb;
  mode_e            mode;
  logic [PW-1:0]    pos_q, pos_d;
  dir_e             dir_q, dir_d;
  logic [NLEDS-1:0] led_q, led_d;
  logic             sweep_q, sweep_d;

  assign mode = mode_e'(i_mode);

  strobe_gen #(.DIV(DIV)) u_stb (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (i_en),
    .i_clr   (i_restart),
    .o_stb   (stb)
  );

  always_comb begin
    pos_d   = pos_q;
    dir_d   = dir_q;
    sweep_d = 1'b0;
    if (i_restart) begin
      pos_d = '0;
      dir_d = DIR_UP;
    end else if (stb) begin
      unique case (mode)
        MODE_BOUNCE: begin
          if (dir_q == DIR_UP) begin
            if (pos_q == POS_LAST) begin
              pos_d = POS_LAST - PW'(1);
              dir_d = DIR_DN;
            end else begin
              pos_d = pos_q + PW'(1);
            end
          end else begin
            if (pos_q == '0) begin
              pos_d = PW'(1);
              dir_d = DIR_UP;
            end else begin
              pos_d = pos_q - PW'(1);
            end
          end
          // Bounce only ever lands on 0 by stepping down, so that is the sweep.
          sweep_d = (pos_d == '0);
        end
        MODE_WRAPUP: begin
          pos_d   = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
          dir_d   = DIR_UP;
          sweep_d = (pos_q == POS_LAST);
        end
        MODE_WRAPDN: begin
          pos_d   = (pos_q == '0) ? POS_LAST : pos_q - PW'(1);
          dir_d   = DIR_DN;
          sweep_d = (pos_q == '0);
        end
        default: ;
      endcase
    end
    led_d = NLEDS'(1) << pos_d;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pos_q   <= '0;
      dir_q   <= DIR_UP;
      led_q   <= NLEDS'(1);
      sweep_q <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
      sweep_q <= sweep_d;
    end
  end

  assign o_pos   = pos_q;
  assign o_led   = led_q;
  assign o_sweep = sweep_q;

  a_onehot: assert property (@(posedge i_clk) disable iff (i_reset) $onehot(o_led));
  a_pos_range: assert property (@(posedge i_clk) disable iff (i_reset)
    int'(o_pos) < NLEDS);
  a_sweep_single: assert property (@(posedge i_clk) disable iff (i_reset)
    !(o_sweep && $past(o_sweep)));

endmodule

// File: tb/tb_ledwalker_n.sv
// Randomised and directed checks of ledwalker_n against a behavioural walk model.
module tb_ledwalker_n;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic         clk = 1'b0;
  logic         rst, en, restart;
  logic [1:0]   mode;
  logic [N-1:0] led;
  logic [1:0]   pos;
  logic         sweep;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_cnt, m_pos, m_dir;
  logic m_sweep;

  always #5 clk = ~clk;

  ledwalker_n #(.NLEDS(N), .CLOCK_RATE_HZ(4), .STEP_RATE_HZ(1)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_en      (en),
    .i_restart (restart),
    .i_mode    (mode),
    .o_led     (led),
    .o_pos     (pos),
    .o_sweep   (sweep)
  );

  task automatic m_reset();
    m_cnt = 0; m_pos = 0; m_dir = 1; m_sweep = 1'b0;
  endtask

  // One clock: model applies the walk rules to the inputs present at the edge.
  task automatic cyc();
    bit stb;
    int np;
    @(posedge clk);
    stb = en && (m_cnt == DIV - 1);
    if (restart) begin
      m_cnt = 0; m_pos = 0; m_dir = 1; m_sweep = 1'b0;
    end else begin
      if (en) m_cnt = (m_cnt + 1) % DIV;
      m_sweep = 1'b0;
      if (stb) begin
        case (mode)
          2'd0: begin
            np = m_pos + m_dir;
            if (np > N - 1) begin np = N - 2; m_dir = -1; end
            else if (np < 0) begin np = 1; m_dir = 1; end
            m_sweep = (np == 0);
            m_pos = np;
          end
          2'd1: begin m_sweep = (m_pos == N - 1); m_pos = (m_pos + 1) % N; m_dir = 1; end
          2'd2: begin m_sweep = (m_pos == 0); m_pos = (m_pos + N - 1) % N; m_dir = -1; end
          default: ;
        endcase
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; restart = 1'b0; mode = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (led !== 4'b0001 || pos !== 2'd0 || sweep !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: led=%b pos=%0d sweep=%b, want led=0001 pos=0 sweep=0", led, pos, sweep);
    end
    en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_bounce();
    int exp_led[8] = '{1, 2, 4, 8, 4, 2, 1, 2};
    int got[8];
    int idx = 1;
    int sweeps = 0;
    logic [N-1:0] prev = led;
    got[0] = int'(led);
    for (int c = 0; c < 40 && idx < 8; c++) begin
      cyc();
      n_cmp++;
      if (pos !== 2'(m_pos) || led !== (4'b0001 << m_pos) || sweep !== m_sweep) begin
        n_bad++;
        $display("FAIL bounce_cycle: pos=%0d led=%b sweep=%b, want pos=%0d sweep=%b", pos, led, sweep, m_pos, m_sweep);
      end
      if (sweep === 1'b1) sweeps++;
      if (led !== prev) begin got[idx] = int'(led); idx++; prev = led; end
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i >= idx || got[i] != exp_led[i]) begin
        n_bad++;
        $display("FAIL bounce_seq[%0d]: got %0d, want %0d", i, (i < idx) ? got[i] : -1, exp_led[i]);
      end
    end
    n_cmp++;
    if (sweeps != 1) begin
      n_bad++;
      $display("FAIL bounce_sweeps: got %0d pulses, want 1", sweeps);
    end
  endtask

  task automatic test_wrap();
    int exp_up[10] = '{2, 4, 8, 1, 2, 4, 8, 1, 2, 4};
    int exp_dn[3]  = '{1, 0, 3};
    int got[10];
    int idx = 0;
    int sweeps = 0;
    int sw_at3 = 0;
    logic [N-1:0] prev;
    restart = 1'b1; cyc(); restart = 1'b0;
    mode = 2'd1;
    prev = led;
    for (int c = 0; c < 40; c++) begin
      cyc();
      n_cmp++;
      if (pos !== 2'(m_pos) || led !== (4'b0001 << m_pos) || sweep !== m_sweep) begin
        n_bad++;
        $display("FAIL wrapup_cycle: pos=%0d led=%b sweep=%b, want pos=%0d sweep=%b", pos, led, sweep, m_pos, m_sweep);
      end
      if (sweep === 1'b1) sweeps++;
      if (led !== prev && idx < 10) begin got[idx] = int'(led); idx++; end
      prev = led;
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (i >= idx || got[i] != exp_up[i]) begin
        n_bad++;
        $display("FAIL wrapup_seq[%0d]: got %0d, want %0d", i, (i < idx) ? got[i] : -1, exp_up[i]);
      end
    end
    n_cmp++;
    if (sweeps != 2) begin
      n_bad++;
      $display("FAIL wrapup_sweeps: got %0d, want 2", sweeps);
    end
    mode = 2'd2;
    idx = 0; sweeps = 0;
    prev = led;
    for (int c = 0; c < 12; c++) begin
      cyc();
      n_cmp++;
      if (pos !== 2'(m_pos) || led !== (4'b0001 << m_pos) || sweep !== m_sweep) begin
        n_bad++;
        $display("FAIL wrapdn_cycle: pos=%0d led=%b sweep=%b, want pos=%0d sweep=%b", pos, led, sweep, m_pos, m_sweep);
      end
      if (sweep === 1'b1) begin sweeps++; if (pos === 2'd3) sw_at3++; end
      if (led !== prev && idx < 3) begin got[idx] = int'(pos); idx++; end
      prev = led;
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= idx || got[i] != exp_dn[i]) begin
        n_bad++;
        $display("FAIL wrapdn_seq[%0d]: got %0d, want %0d", i, (i < idx) ? got[i] : -1, exp_dn[i]);
      end
    end
    n_cmp++;
    if (sweeps != 1 || sw_at3 != 1) begin
      n_bad++;
      $display("FAIL wrapdn_sweeps: got %0d (at pos3 %0d), want 1 at pos3", sweeps, sw_at3);
    end
  endtask

  task automatic test_enable_freeze();
    int found = 0;
    int held;
    int lat = -1;
    mode = 2'd0;
    for (int c = 0; c < 8 && !found; c++) begin
      cyc();
      if (m_cnt == 2) found = 1;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL freeze_setup: counter phase 2 not reached, want reached"); end
    en = 1'b0;
    held = int'(pos);
    for (int c = 0; c < 7; c++) begin
      cyc();
      n_cmp++;
      if (pos !== 2'(held) || led !== (4'b0001 << held) || sweep !== 1'b0 || pos !== 2'(m_pos)) begin
        n_bad++;
        $display("FAIL freeze_hold: pos=%0d led=%b sweep=%b, want pos=%0d", pos, led, sweep, held);
      end
    end
    en = 1'b1;
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      cyc();
      if (pos !== 2'(held)) lat = c;
    end
    n_cmp++;
    if (lat != 2) begin
      n_bad++;
      $display("FAIL freeze_resume: step after %0d clocks, want 2", lat);
    end
  endtask

  task automatic test_hold();
    int found = 0;
    int held;
    int moved = 0;
    mode = 2'd0;
    for (int c = 0; c < 40 && !found; c++) begin
      cyc();
      if (m_dir == -1 && m_pos == N - 2) found = 1;
    end
    n_cmp++;
    if (!found || pos !== 2'(N - 2)) begin
      n_bad++;
      $display("FAIL hold_setup: pos=%0d found=%0d, want pos=%0d moving down", pos, found, N - 2);
    end
    mode = 2'd3;
    held = int'(pos);
    for (int c = 0; c < 20; c++) begin
      cyc();
      n_cmp++;
      if (pos !== 2'(held) || sweep !== 1'b0 || led !== (4'b0001 << held)) begin
        n_bad++;
        $display("FAIL hold_cycle: pos=%0d sweep=%b, want pos=%0d sweep=0", pos, sweep, held);
      end
    end
    mode = 2'd0;
    for (int c = 0; c < 8 && !moved; c++) begin
      cyc();
      if (pos !== 2'(held)) moved = 1;
    end
    n_cmp++;
    if (!moved || pos !== 2'(held - 1)) begin
      n_bad++;
      $display("FAIL hold_resume_down: pos=%0d, want %0d", pos, held - 1);
    end
  endtask

  task automatic test_restart();
    int found = 0;
    int lat = -1;
    mode = 2'd0;
    for (int c = 0; c < 60 && !found; c++) begin
      cyc();
      if (m_pos == 3 && m_cnt == DIV - 1) found = 1;
    end
    n_cmp++;
    if (!found || pos !== 2'd3) begin
      n_bad++;
      $display("FAIL restart_setup: pos=%0d found=%0d, want pos=3 at strobe", pos, found);
    end
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    n_cmp++;
    if (pos !== 2'd0 || led !== 4'b0001 || sweep !== 1'b0) begin
      n_bad++;
      $display("FAIL restart_now: pos=%0d led=%b sweep=%b, want pos=0 led=0001 sweep=0", pos, led, sweep);
    end
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      cyc();
      if (pos !== 2'd0) lat = c;
    end
    n_cmp++;
    if (lat != 4 || pos !== 2'd1) begin
      n_bad++;
      $display("FAIL restart_next: step after %0d clocks to pos %0d, want 4 clocks to pos 1", lat, pos);
    end
  endtask

  task automatic test_async_reset();
    int found = 0;
    int first = -1;
    mode = 2'd0;
    for (int c = 0; c < 40 && !found; c++) begin
      cyc();
      if (m_pos == 2 && m_dir == -1) found = 1;
    end
    n_cmp++;
    if (!found || pos !== 2'd2) begin
      n_bad++;
      $display("FAIL areset_setup: pos=%0d, want 2 moving down", pos);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (pos !== 2'd0 || led !== 4'b0001 || sweep !== 1'b0) begin
      n_bad++;
      $display("FAIL areset_now: pos=%0d led=%b sweep=%b, want pos=0 led=0001 sweep=0", pos, led, sweep);
    end
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      n_cmp++;
      if (pos !== 2'(m_pos) || led !== (4'b0001 << m_pos) || sweep !== m_sweep) begin
        n_bad++;
        $display("FAIL areset_walk: pos=%0d led=%b sweep=%b, want pos=%0d sweep=%b", pos, led, sweep, m_pos, m_sweep);
      end
      if (first < 0 && pos !== 2'd0) first = int'(pos);
    end
    n_cmp++;
    if (first != 1) begin
      n_bad++;
      $display("FAIL areset_upward: first step to %0d, want 1", first);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      en      = ($urandom_range(0, 9) != 0);
      restart = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 11) == 0) mode = 2'($urandom_range(0, 3));
      cyc();
      n_cmp++;
      if (pos !== 2'(m_pos) || led !== (4'b0001 << m_pos) || sweep !== m_sweep) begin
        n_bad++;
        $display("FAIL random_cycle %0d: pos=%0d led=%b sweep=%b, want pos=%0d sweep=%b", c, pos, led, sweep, m_pos, m_sweep);
      end
    end
    en = 1'b1; restart = 1'b0;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_bounce();
    test_wrap();
    test_enable_freeze();
    test_hold();
    test_restart();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
